// File: rtl/sd_register_bank.sv
// sd_register_bank
//   Bank of MEM_DEPTH registers, each DATA_WIDTH bits wide. The host bus reaches
//   it through a four-phase req/ack handshake. One access covers 1..LANES
//   consecutive registers. Each register can be read-only or write-1-to-clear
//   from the bus, and hardware may set bits in any register on any cycle.
//   Accesses that run past the last register are rejected with err.
//
// Ports
//   clk          sole clock, rising edge
//   reset_n      asynchronous active-low reset
//   req          four-phase request; held high until ack is seen
//   wnr          1 = write, 0 = read; stable while req is high
//   size         number of registers in the access, minus one
//   address      first register of the access
//   data_in      write data; lane k goes to register address+k
//   hw_set       per-bit sticky set from hardware, flat, register i at [DATA_WIDTH*i +: DATA_WIDTH]
//   ack          access done; held until req drops
//   err          valid with ack; the access ran out of range
//   data_out     read data; lane k is register address+k
//   mem_data_out flat view of every register for the SD engines
module sd_register_bank #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int MEM_DEPTH  = 1 << ADDR_WIDTH,
    parameter int LANES      = 4,
    parameter logic [MEM_DEPTH-1:0] RO_MASK  = '0,
    parameter logic [MEM_DEPTH-1:0] W1C_MASK = '0,
    localparam int SIZE_W = $clog2(LANES)
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            req,
    input  logic                            wnr,
    input  logic [SIZE_W-1:0]               size,
    input  logic [ADDR_WIDTH-1:0]           address,
    input  logic [LANES*DATA_WIDTH-1:0]     data_in,
    input  logic [MEM_DEPTH*DATA_WIDTH-1:0] hw_set,
    output logic                            ack,
    output logic                            err,
    output logic [LANES*DATA_WIDTH-1:0]     data_out,
    output logic [MEM_DEPTH*DATA_WIDTH-1:0] mem_data_out
);

    localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_ACK  = 1'b1;

    // Highest legal register number, at the widened address width.
    localparam logic [ADDR_WIDTH:0] LAST_REG = (ADDR_WIDTH+1)'(MEM_DEPTH - 1);

    logic [0:0]                  state_q, state_d;
    logic                        ack_q, ack_d;
    logic                        err_q, err_d;
    logic [LANES*DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic [DATA_WIDTH-1:0]       mem_q [MEM_DEPTH];
    logic [DATA_WIDTH-1:0]       mem_d [MEM_DEPTH];

    logic [ADDR_WIDTH:0]         last_addr;
    logic                        out_of_range;
    logic [IDX_W-1:0]            reg_idx;
    logic [DATA_WIDTH-1:0]       lane;

    // One extra bit on the end address so that running off the top is reported,
    // not wrapped back to register 0.
    assign last_addr    = {1'b0, address} + (ADDR_WIDTH+1)'(size);
    assign out_of_range = (last_addr > LAST_REG);

    always_comb begin
        state_d    = state_q;
        ack_d      = ack_q;
        err_d      = err_q;
        data_out_d = data_out_q;
        mem_d      = mem_q;
        reg_idx    = '0;
        lane       = '0;

        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    state_d    = ST_ACK;
                    ack_d      = 1'b1;
                    err_d      = out_of_range;
                    data_out_d = '0;
                    if (!out_of_range) begin
                        for (int k = 0; k < LANES; k++) begin
                            if (k <= int'(size)) begin
                                reg_idx = IDX_W'(int'(address) + k);
                                lane    = data_in[k*DATA_WIDTH +: DATA_WIDTH];
                                if (wnr) begin
                                    if (RO_MASK[reg_idx]) begin
                                        mem_d[reg_idx] = mem_q[reg_idx];
                                    end else if (W1C_MASK[reg_idx]) begin
                                        mem_d[reg_idx] = mem_q[reg_idx] & ~lane;
                                    end else begin
                                        mem_d[reg_idx] = lane;
                                    end
                                end else begin
                                    data_out_d[k*DATA_WIDTH +: DATA_WIDTH] = mem_q[reg_idx];
                                end
                            end
                        end
                    end
                end
            end
            default: begin
                // req still high here is the tail of the answered request.
                if (!req) begin
                    state_d    = ST_IDLE;
                    ack_d      = 1'b0;
                    err_d      = 1'b0;
                    data_out_d = '0;
                end
            end
        endcase

        // Hardware set is merged last so it wins over a bus clear or overwrite
        // of the same bit, and it reaches read-only registers too.
        for (int i = 0; i < MEM_DEPTH; i++) begin
            mem_d[i] = mem_d[i] | hw_set[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            data_out_q <= '0;
            for (int i = 0; i < MEM_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
            data_out_q <= data_out_d;
            mem_q      <= mem_d;
        end
    end

    assign ack      = ack_q;
    assign err      = err_q;
    assign data_out = data_out_q;

    for (genvar g = 0; g < MEM_DEPTH; g++) begin : g_flat
        assign mem_data_out[g*DATA_WIDTH +: DATA_WIDTH] = mem_q[g];
    end

endmodule

// File: tb/tb_sd_register_bank.sv
// Bench for sd_register_bank: directed handshake, attribute and range steps,
// a randomized phase, and a reset-during-access step, all checked against a
// register-array model of the bank kept in this file.
module tb_sd_register_bank;

    localparam int DW    = 8;
    localparam int AW    = 8;
    localparam int DEPTH = 256;
    localparam int LANES = 4;
    localparam logic [DEPTH-1:0] RO_P  = {{(DEPTH-1){1'b0}}, 1'b1} << 8'h20;
    localparam logic [DEPTH-1:0] W1C_P = {{(DEPTH-1){1'b0}}, 1'b1} << 8'h30;

    logic                  clk = 1'b0;
    logic                  reset_n;
    logic                  req;
    logic                  wnr;
    logic [1:0]            size;
    logic [AW-1:0]         address;
    logic [LANES*DW-1:0]   data_in;
    logic [DEPTH*DW-1:0]   hw_set;
    logic                  ack;
    logic                  err;
    logic [LANES*DW-1:0]   data_out;
    logic [DEPTH*DW-1:0]   mem_data_out;

    sd_register_bank #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_DEPTH(DEPTH), .LANES(LANES),
        .RO_MASK(RO_P), .W1C_MASK(W1C_P)
    ) dut (
        .clk(clk), .reset_n(reset_n), .req(req), .wnr(wnr), .size(size),
        .address(address), .data_in(data_in), .hw_set(hw_set), .ack(ack),
        .err(err), .data_out(data_out), .mem_data_out(mem_data_out)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no end of run, expected finish");
        $fatal(1, "watchdog expired");
    end

    // Reference model: register contents, handshake outputs, hw_set bytes.
    int          ref_mem [DEPTH];
    int          hw [DEPTH];
    bit          ref_ack;
    bit          ref_err;
    logic [31:0] ref_dout;
    int          n_tests = 0;
    int          n_fail  = 0;

    function automatic bit is_ro(int r);
        return r == 32'h20;
    endfunction

    function automatic bit is_w1c(int r);
        return r == 32'h30;
    endfunction

    function automatic logic [7:0] reg_at(int i);
        return mem_data_out[8*i +: 8];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_mem(input string tag);
        logic [DEPTH*DW-1:0] exp;
        int first;
        for (int i = 0; i < DEPTH; i++) exp[8*i +: 8] = 8'(ref_mem[i]);
        n_tests++;
        assert (mem_data_out === exp) else begin
            n_fail++;
            first = 0;
            for (int i = DEPTH - 1; i >= 0; i--)
                if (mem_data_out[8*i +: 8] !== exp[8*i +: 8]) first = i;
            $error("FAIL %s: reg 0x%0h observed 0x%0h expected 0x%0h", tag, first,
                   mem_data_out[8*first +: 8], exp[8*first +: 8]);
        end
    endtask

    task automatic check_all(input string tag);
        chk($sformatf("%s_ack", tag), {31'b0, ack}, {31'b0, ref_ack});
        chk($sformatf("%s_err", tag), {31'b0, err}, {31'b0, ref_err});
        chk($sformatf("%s_dout", tag), data_out, ref_dout);
        chk_mem($sformatf("%s_mem", tag));
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 0;
        ref_ack  = 1'b0;
        ref_err  = 1'b0;
        ref_dout = '0;
    endtask

    // Advance one clock: work out what the bank should do with the inputs
    // present now, then let the edge happen and sample 1 time unit later.
    task automatic step();
        int nxt [DEPTH];
        int last;
        int r;
        int ln;
        for (int i = 0; i < DEPTH; i++) nxt[i] = ref_mem[i];
        if (!ref_ack && req === 1'b1) begin
            ref_ack  = 1'b1;
            ref_dout = '0;
            last     = int'(address) + int'(size);
            if (last > DEPTH - 1) begin
                ref_err = 1'b1;
            end else begin
                ref_err = 1'b0;
                for (int k = 0; k <= int'(size); k++) begin
                    r  = int'(address) + k;
                    ln = int'(data_in[8*k +: 8]);
                    if (wnr) begin
                        if (is_ro(r)) nxt[r] = ref_mem[r];
                        else if (is_w1c(r)) nxt[r] = ref_mem[r] & (255 - ln);
                        else nxt[r] = ln;
                    end else begin
                        ref_dout[8*k +: 8] = 8'(ref_mem[r]);
                    end
                end
            end
        end else if (ref_ack && req === 1'b0) begin
            ref_ack  = 1'b0;
            ref_err  = 1'b0;
            ref_dout = '0;
        end
        for (int i = 0; i < DEPTH; i++) begin
            nxt[i] = (nxt[i] | hw[i]) & 255;
            hw_set[8*i +: 8] = 8'(hw[i]);
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = nxt[i];
    endtask

    task automatic start(input string tag, input bit w, input int sz, input int a,
                         input logic [31:0] d);
        wnr     = w;
        size    = 2'(sz);
        address = 8'(a);
        data_in = d;
        req     = 1'b1;
        step();
        check_all(tag);
    endtask

    task automatic finish(input string tag, input int hold);
        for (int i = 0; i < hold; i++) begin
            step();
            check_all($sformatf("%s_hold", tag));
        end
        req = 1'b0;
        step();
        check_all($sformatf("%s_drop", tag));
    endtask

    initial begin
        int hidx;
        reset_n = 1'b0;
        req     = 1'b0;
        wnr     = 1'b0;
        size    = '0;
        address = '0;
        data_in = '0;
        for (int i = 0; i < DEPTH; i++) begin
            hw[i] = 0;
            hw_set[8*i +: 8] = 8'h00;
        end
        model_reset();
        #12;
        check_all("reset");
        reset_n = 1'b1;

        // Read of four registers after reset; ack holds while req stays high.
        start("rd0", 1'b0, 3, 32'h00, 32'h0);
        chk("rd0_ack_const", {31'b0, ack}, 32'h1);
        finish("rd0", 3);
        chk("rd0_ack_low", {31'b0, ack}, 32'h0);

        // Multi-lane write, then a partial read back from the middle.
        start("wr10", 1'b1, 3, 32'h10, 32'hDDCCBBAA);
        finish("wr10", 0);
        start("rd12", 1'b0, 1, 32'h12, 32'h0);
        chk("rd12_const", data_out, 32'h0000DDCC);
        chk("reg13_const", {24'b0, reg_at(32'h13)}, 32'hDD);
        finish("rd12", 0);

        // Read-only register ignores the bus but takes hardware set.
        start("ro_wr", 1'b1, 0, 32'h20, 32'h55);
        chk("ro_reg_const", {24'b0, reg_at(32'h20)}, 32'h0);
        finish("ro_wr", 0);
        hw[32'h20] = 32'h01;
        step();
        hw[32'h20] = 0;
        check_all("ro_hw");
        start("ro_rd", 1'b0, 0, 32'h20, 32'h0);
        chk("ro_rd_const", data_out, 32'h01);
        finish("ro_rd", 0);

        // Write-1-to-clear register, including set winning over a same-edge clear.
        hw[32'h30] = 32'hF0;
        step();
        hw[32'h30] = 0;
        chk("w1c_set_const", {24'b0, reg_at(32'h30)}, 32'hF0);
        start("w1c_clr", 1'b1, 0, 32'h30, 32'h30);
        chk("w1c_clr_const", {24'b0, reg_at(32'h30)}, 32'hC0);
        finish("w1c_clr", 0);
        hw[32'h30] = 32'h80;
        start("w1c_race", 1'b1, 0, 32'h30, 32'h80);
        hw[32'h30] = 0;
        chk("w1c_race_const", {24'b0, reg_at(32'h30)}, 32'hC0);
        finish("w1c_race", 0);

        // Range error at the top of the map; nothing written, no wrap to 0.
        start("pre_fe", 1'b1, 1, 32'hFE, 32'h00002211);
        finish("pre_fe", 0);
        start("pre_00", 1'b1, 1, 32'h00, 32'h00008877);
        finish("pre_00", 0);
        start("oor", 1'b1, 3, 32'hFE, 32'hA5A5A5A5);
        chk("oor_err_const", {31'b0, err}, 32'h1);
        chk("oor_fe_const", {24'b0, reg_at(32'hFE)}, 32'h11);
        chk("oor_ff_const", {24'b0, reg_at(32'hFF)}, 32'h22);
        chk("oor_00_const", {24'b0, reg_at(32'h00)}, 32'h77);
        chk("oor_01_const", {24'b0, reg_at(32'h01)}, 32'h88);
        finish("oor", 0);
        start("rd_ff", 1'b0, 0, 32'hFF, 32'h0);
        chk("rd_ff_err_const", {31'b0, err}, 32'h0);
        chk("rd_ff_const", data_out, 32'h22);
        finish("rd_ff", 0);

        // Randomized accesses with occasional hardware set.
        for (int n = 0; n < 150; n++) begin
            int a;
            a = ($urandom_range(0, 3) == 0) ? int'($urandom_range(248, 255))
                                            : int'($urandom_range(0, 255));
            hidx = -1;
            if ($urandom_range(0, 3) == 0) begin
                hidx = int'($urandom_range(0, 255));
                hw[hidx] = int'($urandom_range(1, 255));
            end
            start("rnd", 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), a, $urandom);
            if (hidx >= 0) hw[hidx] = 0;
            finish("rnd", int'($urandom_range(0, 2)));
        end

        // Reset in the middle of a write handshake, req kept high through it.
        start("rst_wr", 1'b1, 3, 32'h40, 32'h44332211);
        chk("rst_wr_const", {24'b0, reg_at(32'h40)}, 32'h11);
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        chk("rst_ack_const", {31'b0, ack}, 32'h0);
        chk("rst_reg40_const", {24'b0, reg_at(32'h40)}, 32'h0);
        check_all("rst_mid");
        #2;
        reset_n = 1'b1;
        step();
        check_all("rst_again");
        chk("rst_again_ack_const", {31'b0, ack}, 32'h1);
        chk("rst_again_reg40_const", {24'b0, reg_at(32'h40)}, 32'h11);
        finish("rst_again", 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
